// File: rtl/z_core_reg_file_mp.sv
// Multi-port integer register file for Z-Core: N async read ports, M write ports,
// optional write-to-read forwarding and a per-register busy scoreboard.
module z_core_reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rs_addr,
    output logic [NUM_RD*XLEN-1:0]   rs_data,
    output logic [NUM_RD-1:0]        rs_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_rd,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [XLEN-1:0]     r_regs [NUM_REGS-1:1];
    logic [NUM_REGS-1:0] r_busy;

    logic [NUM_REGS-1:0] w_we;
    logic [XLEN-1:0]     w_wd   [NUM_REGS];
    logic [XLEN-1:0]     w_file [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy_next;

    // Per-register write decode; later ports overwrite earlier ones, so the
    // highest-indexed matching port wins for both storage and forwarding.
    // Gating with reset keeps forwarded data at zero while reset is held.
    always_comb begin
        w_we = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wd[r] = '0;
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (!reset && wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
                    w_we[r] = 1'b1;
                    w_wd[r] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        w_file[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_file[r] = r_regs[r];
        end
    end

    // A new issue supersedes a writeback from the previous producer.
    always_comb begin
        w_busy_next = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue_en && (issue_rd == AW'(r))) begin
                w_busy_next[r] = 1'b1;
            end else if (w_we[r]) begin
                w_busy_next[r] = 1'b0;
            end else begin
                w_busy_next[r] = r_busy[r];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            r_busy <= w_busy_next;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_we[r]) begin
                    r_regs[r] <= w_wd[r];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_fwd;

            assign w_addr = rs_addr[gi*AW +: AW];
            assign w_fwd  = (BYPASS != 0) && w_we[w_addr];
            assign rs_data[gi*XLEN +: XLEN] = w_fwd ? w_wd[w_addr] : w_file[w_addr];
            assign rs_busy[gi] = r_busy[w_addr] && !w_fwd;
        end
    endgenerate

    assign busy_vec = r_busy;

endmodule

// File: tb/tb_z_core_reg_file_mp.sv
// Bench for z_core_reg_file_mp: one instance without forwarding (1 write port)
// and one with forwarding (2 write ports), checked through an expectation queue.
module tb_z_core_reg_file_mp;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    // Instance 0: BYPASS=0, NUM_WR=1
    logic [9:0]  d0_rs_addr;
    logic [63:0] d0_rs_data;
    logic [1:0]  d0_rs_busy;
    logic [0:0]  d0_wr_en;
    logic [4:0]  d0_wr_addr;
    logic [31:0] d0_wr_data;
    logic        d0_issue_en;
    logic [4:0]  d0_issue_rd;
    logic [31:0] d0_busy_vec;

    // Instance 1: BYPASS=1, NUM_WR=2
    logic [9:0]  d1_rs_addr;
    logic [63:0] d1_rs_data;
    logic [1:0]  d1_rs_busy;
    logic [1:0]  d1_wr_en;
    logic [9:0]  d1_wr_addr;
    logic [63:0] d1_wr_data;
    logic        d1_issue_en;
    logic [4:0]  d1_issue_rd;
    logic [31:0] d1_busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    z_core_reg_file_mp #(
        .XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)
    ) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (d0_rs_addr),
        .rs_data  (d0_rs_data),
        .rs_busy  (d0_rs_busy),
        .wr_en    (d0_wr_en),
        .wr_addr  (d0_wr_addr),
        .wr_data  (d0_wr_data),
        .issue_en (d0_issue_en),
        .issue_rd (d0_issue_rd),
        .busy_vec (d0_busy_vec)
    );

    z_core_reg_file_mp #(
        .XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)
    ) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (d1_rs_addr),
        .rs_data  (d1_rs_data),
        .rs_busy  (d1_rs_busy),
        .wr_en    (d1_wr_en),
        .wr_addr  (d1_wr_addr),
        .wr_data  (d1_wr_data),
        .issue_en (d1_issue_en),
        .issue_rd (d1_issue_rd),
        .busy_vec (d1_busy_vec)
    );

    // Observation points selected by index so expectations can be queued ahead.
    localparam int D0_P0 = 0, D0_P1 = 1, D0_BSY = 2, D0_VEC = 3;
    localparam int D1_P0 = 4, D1_P1 = 5, D1_BSY = 6, D1_VEC = 7;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            D0_P0:   return d0_rs_data[31:0];
            D0_P1:   return d0_rs_data[63:32];
            D0_BSY:  return {30'd0, d0_rs_busy};
            D0_VEC:  return d0_busy_vec;
            D1_P0:   return d1_rs_data[31:0];
            D1_P1:   return d1_rs_data[63:32];
            D1_BSY:  return {30'd0, d1_rs_busy};
            D1_VEC:  return d1_busy_vec;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic idle_inputs();
        d0_wr_en = '0; d0_wr_addr = '0; d0_wr_data = '0;
        d0_issue_en = 1'b0; d0_issue_rd = '0;
        d1_wr_en = '0; d1_wr_addr = '0; d1_wr_data = '0;
        d1_issue_en = 1'b0; d1_issue_rd = '0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 time units later,
    // well before the next rising edge.
    task automatic begin_step();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic end_step();
        #2;
        drain();
    endtask

    initial begin
        idle_inputs();
        d0_rs_addr = '0;
        d1_rs_addr = '0;

        // Reset held: writes, issues and forwarding are all suppressed
        #1;
        reset = 1'b1;
        d1_wr_en    = 2'b01;
        d1_wr_addr  = {5'd0, 5'd3};
        d1_wr_data  = {32'd0, 32'd7};
        d1_issue_en = 1'b1;
        d1_issue_rd = 5'd3;
        d1_rs_addr  = {5'd0, 5'd3};
        push_exp("rst_fwd_x3",   D1_P0,  32'd0);
        push_exp("rst_rsbusy",   D1_BSY, 32'd0);
        push_exp("rst_vec1",     D1_VEC, 32'd0);
        push_exp("rst_vec0",     D0_VEC, 32'd0);
        #1;
        drain();
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_exp("rst_hold_x3",  D1_P0,  32'd0);
        push_exp("rst_hold_vec", D1_VEC, 32'd0);
        #2;
        drain();
        reset = 1'b0;
        idle_inputs();

        // A: dut0 writes x5; dut1 both ports write x9 (port 1 wins)
        begin_step();
        d0_wr_en = 1'b1; d0_wr_addr = 5'd5; d0_wr_data = 32'd15;
        d0_rs_addr = {5'd8, 5'd5};
        d1_wr_en = 2'b11; d1_wr_addr = {5'd9, 5'd9};
        d1_wr_data = {32'h0000_5555, 32'h0000_AAAA};
        d1_rs_addr = {5'd0, 5'd9};
        push_exp("A_d0_x5_old",  D0_P0, 32'd0);
        push_exp("A_d0_x8",      D0_P1, 32'd0);
        push_exp("A_d1_fwd_x9",  D1_P0, 32'h0000_5555);
        push_exp("A_d1_x0",      D1_P1, 32'd0);
        end_step();

        // B: dut0 writes x8 (same-cycle read sees old); dut1 writes/issues x0
        begin_step();
        d0_wr_en = 1'b1; d0_wr_addr = 5'd8; d0_wr_data = 32'd25;
        d1_wr_en = 2'b01; d1_wr_addr = {5'd0, 5'd0};
        d1_wr_data = {32'd0, 32'hDEAD_BEEF};
        d1_issue_en = 1'b1; d1_issue_rd = 5'd0;
        push_exp("B_d0_x5",      D0_P0,  32'd15);
        push_exp("B_d0_x8_old",  D0_P1,  32'd0);
        push_exp("B_d1_x9_st",   D1_P0,  32'h0000_5555);
        push_exp("B_d1_x0_fwd",  D1_P1,  32'd0);
        push_exp("B_d1_rsbusy",  D1_BSY, 32'd0);
        end_step();

        // C: dut1 issues x7; same-cycle issue is not yet visible
        begin_step();
        d1_issue_en = 1'b1; d1_issue_rd = 5'd7;
        d1_rs_addr = {5'd0, 5'd7};
        push_exp("C_d0_x5",      D0_P0,  32'd15);
        push_exp("C_d0_x8",      D0_P1,  32'd25);
        push_exp("C_d1_vec",     D1_VEC, 32'd0);
        push_exp("C_d1_rsbusy",  D1_BSY, 32'd0);
        push_exp("C_d1_x0",      D1_P1,  32'd0);
        push_exp("C_d1_x7",      D1_P0,  32'd0);
        end_step();

        // D: dut1 x7 busy; dut0 issues x6
        begin_step();
        d0_issue_en = 1'b1; d0_issue_rd = 5'd6;
        d0_rs_addr = {5'd5, 5'd6};
        push_exp("D_d0_rsbusy",  D0_BSY, 32'd0);
        push_exp("D_d0_vec",     D0_VEC, 32'd0);
        push_exp("D_d0_x5",      D0_P1,  32'd15);
        push_exp("D_d1_vec",     D1_VEC, 32'h0000_0080);
        push_exp("D_d1_rsbusy",  D1_BSY, 32'd1);
        end_step();

        // E: writebacks; dut0 has no forwarding so x6 stays busy this cycle
        begin_step();
        d0_wr_en = 1'b1; d0_wr_addr = 5'd6; d0_wr_data = 32'd77;
        d1_wr_en = 2'b01; d1_wr_addr = {5'd0, 5'd7}; d1_wr_data = {32'd0, 32'd42};
        push_exp("E_d0_rsbusy",  D0_BSY, 32'd1);
        push_exp("E_d0_x6_old",  D0_P0,  32'd0);
        push_exp("E_d0_vec",     D0_VEC, 32'h0000_0040);
        push_exp("E_d1_x7_fwd",  D1_P0,  32'd42);
        push_exp("E_d1_rsbusy",  D1_BSY, 32'd0);
        push_exp("E_d1_vec",     D1_VEC, 32'h0000_0080);
        end_step();

        // F: busy bits cleared by the writebacks
        begin_step();
        push_exp("F_d0_x6",      D0_P0,  32'd77);
        push_exp("F_d0_rsbusy",  D0_BSY, 32'd0);
        push_exp("F_d0_vec",     D0_VEC, 32'd0);
        push_exp("F_d1_x7",      D1_P0,  32'd42);
        push_exp("F_d1_vec",     D1_VEC, 32'd0);
        push_exp("F_d1_rsbusy",  D1_BSY, 32'd0);
        end_step();

        // G: dut1 issues x7 again
        begin_step();
        d1_issue_en = 1'b1; d1_issue_rd = 5'd7;
        push_exp("G_d1_vec",     D1_VEC, 32'd0);
        end_step();

        // H: issue and writeback to busy x7 in the same cycle
        begin_step();
        d1_issue_en = 1'b1; d1_issue_rd = 5'd7;
        d1_wr_en = 2'b10; d1_wr_addr = {5'd7, 5'd0}; d1_wr_data = {32'd99, 32'd0};
        push_exp("H_d1_x7_fwd",  D1_P0,  32'd99);
        push_exp("H_d1_rsbusy",  D1_BSY, 32'd0);
        push_exp("H_d1_vec",     D1_VEC, 32'h0000_0080);
        end_step();

        // I: issue won, write stored
        begin_step();
        push_exp("I_d1_vec",     D1_VEC, 32'h0000_0080);
        push_exp("I_d1_x7",      D1_P0,  32'd99);
        push_exp("I_d1_rsbusy",  D1_BSY, 32'd1);
        push_exp("I_d0_x5",      D0_P1,  32'd15);
        end_step();

        // Mid-cycle reset, no clock edge in between
        reset = 1'b1;
        push_exp("R_d0_x5",      D0_P1,  32'd0);
        push_exp("R_d0_vec",     D0_VEC, 32'd0);
        push_exp("R_d1_x7",      D1_P0,  32'd0);
        push_exp("R_d1_vec",     D1_VEC, 32'd0);
        push_exp("R_d1_rsbusy",  D1_BSY, 32'd0);
        #1;
        drain();

        begin_step();
        reset = 1'b0;

        // K/L: writes resume after reset release
        begin_step();
        d0_wr_en = 1'b1; d0_wr_addr = 5'd5; d0_wr_data = 32'd3;
        push_exp("K_d0_x5_old",  D0_P1,  32'd0);
        end_step();

        begin_step();
        push_exp("L_d0_x5",      D0_P1,  32'd3);
        end_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
